pwm_cmd_sequencer: RTL and testbench
====================================

Name: pwm_cmd_sequencer

Overview:
- Upstream feeder for the 4-channel PWM controller: buffers CPU duty-cycle writes in a small FIFO.
- Drives the controller's 32-bit command word, changing it only at PWM period boundaries (controller count == 0) so no output period is truncated or glitched.
- Sits between the memory-mapped CPU write path and the PWM controller's command input; consumes the controller's count output.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, 20, duty/count width; must match controller.
- HOLD_CYC, 2, cycles command is held after an issue before the next boundary is armed; >= 1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low; sampled on clk rising edge
- wr_en  in  1  CPU write strobe, one entry per asserted cycle
- wr_chan  in  2  target PWM channel 0..3
- wr_duty  in  CNT_W  duty value for channel
- wr_ready  out  1  = !full (registered state); writes with wr_ready=0 are dropped
- pwm_count  in  CNT_W  controller period counter
- command  out  32  to controller: [31:30]=chan, [29:CNT_W]=0, [CNT_W-1:0]=duty
- cmd_valid  out  1  one-cycle pulse in the cycle command changes
- busy  out  1  FIFO non-empty or state != IDLE
- overflow  out  1  sticky; set on a dropped write, cleared only by reset
- level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (reset==0 at a clk edge): FIFO flushed, level=0, command=32'h0, cmd_valid=0, overflow=0, busy=0, wr_ready=1, state=IDLE. Reset mid-issue or mid-hold aborts immediately; pending entries are lost.
- Push: on wr_en && !full, write {wr_chan, wr_duty} at the tail. level increments next cycle.
- Full: wr_en && full drops the write and sets overflow. A same-cycle pop does not rescue it, because full is a registered state.
- Simultaneous push and pop: both happen and level is unchanged.
- FSM:
  - IDLE: if !empty go to ARM.
  - ARM: wait for pwm_count == 0. In that cycle, pop the head; next cycle command = popped word, cmd_valid=1, go to HOLD.
  - HOLD: count HOLD_CYC cycles with command stable. Then go to ARM if !empty, else IDLE.
- Each issue needs a fresh boundary. An entry popped at the count==0 cycle lands on command one cycle later.
- At most one command per boundary. Further entries wait for later boundaries, even when HOLD ends while pwm_count is still 0 (e.g. controller in reset with count stuck at 0: one issue every HOLD_CYC+2 cycles).
- Latency, empty FIFO at a boundary: write at cycle t, count==0 at cycle b >= t+2 → command valid at b+1.
- command holds its last value indefinitely between issues. It is never returned to 0 except by reset.
- Channel order is strict FIFO. Writes to the same channel are all issued in order unless the optional feature is compiled in.
- pwm_count wrap is the controller's concern; this block compares only against 0.

Optional Feature:
- Macro: PWM_CMD_COALESCE_EN.
- Defined:
  - A write whose wr_chan matches a pending FIFO entry (not the entry being popped that cycle) overwrites that entry's duty in place.
  - Position is kept and level is unchanged.
  - Accepted even when full; overflow is not set.
  - If several entries match, the youngest is updated.
  - wr_ready still = !full, so software may write a matching channel when full.
- Undefined: every accepted write appends; duplicates are issued in order.

Test Plan:
- Reset, then write chan=1 duty=20'h80000 while pwm_count held at 5; release pwm_count to 0 at cycle b → command=32'h40080000 at b+1, cmd_valid pulse one cycle, level returns to 0, busy falls after HOLD.
- Write 4 entries (chan 0..3, duties 1,2,3,4), then a 5th write → wr_ready=0 after the 4th, 5th dropped, overflow=1. Four boundaries → commands 32'h00000001, 32'h40000002, 32'h80000003, 32'hC0000004 in order.
- Same-cycle push and pop with level=2 → level stays 2, popped word issued, pushed word at tail.
- Assert reset=0 during HOLD with 3 entries pending → next cycle command=0, level=0, overflow=0, busy=0; no further cmd_valid without new writes.
- pwm_count stuck at 0, two entries queued, HOLD_CYC=2 → second cmd_valid exactly 4 cycles after the first.
- PWM_CMD_COALESCE_EN defined: write chan=2 duty=10, then chan=2 duty=99 before the boundary → level=1, issued command=32'h80000063. Without the macro: level=2, commands ...0A then ...63.

Source files
------------

// File: rtl/pwm_cmd_sequencer.sv
// Command FIFO and boundary-synchronised issuer feeding the 4-channel PWM controller.
// Optional build macro PWM_CMD_COALESCE_EN: a write to a channel already queued rewrites that entry's duty.
//
// state | meaning
// IDLE  | FIFO empty, nothing to issue
// ARM   | entry pending, waiting for pwm_count_i == 0 to pop the head
// HOLD  | command just issued, held for HOLD_CYC cycles before re-arming
module pwm_cmd_sequencer #(
    parameter int DEPTH    = 4,
    parameter int CNT_W    = 20,
    parameter int HOLD_CYC = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       wr_en_i,
    input  logic [1:0]                 wr_chan_i,
    input  logic [CNT_W-1:0]           wr_duty_i,
    output logic                       wr_ready_o,
    input  logic [CNT_W-1:0]           pwm_count_i,
    output logic [31:0]                command_o,
    output logic                       cmd_valid_o,
    output logic                       busy_o,
    output logic                       overflow_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = AW + 1;
    localparam int HW   = $clog2(HOLD_CYC + 1);
    localparam int EW   = 2 + CNT_W;
    localparam int PADW = 30 - CNT_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [LW-1:0]   level_q;
    logic [31:0]     cmd_q;
    logic            vld_q;
    logic            ovf_q;

    logic            full, empty, pop, push, drop, co_hit;
    logic [EW-1:0]   head;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign head  = mem_q[rd_ptr_q];
    assign pop   = (state_q == S_ARM) && (pwm_count_i == '0) && !empty;

`ifdef PWM_CMD_COALESCE_EN
    logic [AW-1:0] co_idx;
    logic [AW-1:0] scan_idx;

    // Youngest matching entry wins; the head is excluded while it is leaving.
    always_comb begin
        co_hit   = 1'b0;
        co_idx   = '0;
        scan_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = rd_ptr_q + AW'(k);
            if (wr_en_i && (LW'(k) < level_q) && !(pop && (k == 0)) &&
                (mem_q[scan_idx][EW-1 -: 2] == wr_chan_i)) begin
                co_hit = 1'b1;
                co_idx = scan_idx;
            end
        end
    end
`else
    assign co_hit = 1'b0;
`endif

    assign push = wr_en_i && !full && !co_hit;
    assign drop = wr_en_i && full && !co_hit;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            S_IDLE: begin
                if (!empty) state_d = S_ARM;
            end
            S_ARM: begin
                if (pop) begin
                    state_d = S_HOLD;
                    hold_d  = HW'(HOLD_CYC);
                end
            end
            S_HOLD: begin
                if (hold_q == '0) state_d = empty ? S_IDLE : S_ARM;
                else              hold_d  = hold_q - HW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= {wr_chan_i, wr_duty_i};
`ifdef PWM_CMD_COALESCE_EN
        if (co_hit) mem_q[co_idx][CNT_W-1:0] <= wr_duty_i;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q  <= S_IDLE;
            hold_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            cmd_q    <= '0;
            vld_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_q + LW'(push) - LW'(pop);
            vld_q   <= pop;
            if (pop)  cmd_q <= {head[EW-1 -: 2], {PADW{1'b0}}, head[CNT_W-1:0]};
            if (drop) ovf_q <= 1'b1;
        end
    end

    assign wr_ready_o  = !full;
    assign command_o   = cmd_q;
    assign cmd_valid_o = vld_q;
    assign busy_o      = !empty || (state_q != S_IDLE);
    assign overflow_o  = ovf_q;
    assign level_o     = level_q;

endmodule

// File: tb/tb_pwm_cmd_sequencer.sv
// Self-checking bench for pwm_cmd_sequencer: queue-based reference model plus directed literal checks.
// Honours PWM_CMD_COALESCE_EN when the design is built with it.
module tb_pwm_cmd_sequencer;

    localparam int DEPTH    = 4;
    localparam int CNT_W    = 20;
    localparam int HOLD_CYC = 2;
`ifdef PWM_CMD_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_chan = '0;
    logic [19:0] wr_duty = '0;
    logic [19:0] pwm_count = 20'd5;
    logic        wr_ready, cmd_valid, busy, overflow;
    logic [31:0] command;
    logic [2:0]  level;

    pwm_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W), .HOLD_CYC(HOLD_CYC)) dut (
        .clk_i(clk), .reset_i(reset_n), .wr_en_i(wr_en), .wr_chan_i(wr_chan),
        .wr_duty_i(wr_duty), .wr_ready_o(wr_ready), .pwm_count_i(pwm_count),
        .command_o(command), .cmd_valid_o(cmd_valid), .busy_o(busy),
        .overflow_o(overflow), .level_o(level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int tcyc = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pending entries as a queue; an issue needs a nonempty queue seen
    // at or after the re-arm point, plus count == 0 in the current cycle.
    logic [21:0] q[$];
    logic [31:0] exp_cmd = '0;
    bit          exp_vld = 1'b0;
    bit          exp_ovf = 1'b0;
    int          cyc = 0;
    int          gate = 0;
    int          hold_until = -1;
    int          lvl_prev = 0;

    task automatic model_step();
        int sz;
        bit pop, hit, app;
        int hi;
        logic [21:0] w;
        sz  = q.size();
        hit = 1'b0;
        app = 1'b0;
        hi  = 0;
        if (!reset_n) begin
            q.delete();
            exp_cmd    = '0;
            exp_vld    = 1'b0;
            exp_ovf    = 1'b0;
            gate       = cyc + 1;
            hold_until = -1;
        end else begin
            pop = (sz > 0) && (lvl_prev > 0) && (cyc - 1 >= gate) && (pwm_count == '0);
            if (COAL && wr_en) begin
                for (int k = (pop ? 1 : 0); k < sz; k++)
                    if (q[k][21:20] == wr_chan) begin
                        hit = 1'b1;
                        hi  = k;
                    end
            end
            if (hit) begin
                w = q[hi];
                w[19:0] = wr_duty;
                q[hi] = w;
            end else if (wr_en) begin
                if (sz < DEPTH) app = 1'b1;
                else            exp_ovf = 1'b1;
            end
            if (pop) begin
                w          = q.pop_front();
                exp_cmd    = {w[21:20], 10'b0, w[19:0]};
                gate       = cyc + HOLD_CYC + 1;
                hold_until = cyc + HOLD_CYC + 1;
            end
            exp_vld = pop;
            if (app) q.push_back({wr_chan, wr_duty});
        end
        lvl_prev = sz;
        cyc++;
    endtask

    always @(posedge clk) begin
        #1;
        model_step();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_command", command, exp_cmd);
            chk("m_cmd_valid", {31'b0, cmd_valid}, {31'b0, exp_vld});
            chk("m_overflow", {31'b0, overflow}, {31'b0, exp_ovf});
            chk("m_level", {29'b0, level}, 32'(q.size()));
            chk("m_wr_ready", {31'b0, wr_ready}, {31'b0, q.size() < DEPTH});
            chk("m_busy", {31'b0, busy}, {31'b0, (q.size() > 0) || (cyc <= hold_until)});
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            tcyc++;
        end
    endtask

    task automatic write(input logic [1:0] ch, input logic [19:0] d);
        wr_en = 1'b1;
        wr_chan = ch;
        wr_duty = d;
        step(1);
        wr_en = 1'b0;
    endtask

    task automatic boundary_issue(input string nm, input logic [31:0] exp);
        pwm_count = '0;
        step(1);
        pwm_count = 20'd7;
        chk({nm, "_valid"}, {31'b0, cmd_valid}, 32'd1);
        chk(nm, command, exp);
        step(5);
    endtask

    task automatic wait_vld(input int max, output int at);
        bit ok;
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < max && !ok; i++) begin
            step(1);
            if (cmd_valid) begin
                ok = 1'b1;
                at = tcyc;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_cmd_valid: got timeout expected pulse within %0d cycles", max);
        end
    endtask

    logic [31:0] exp4 [4];
    int t1, t2, npulse;

    initial begin
        step(2);
        chk_en  = 1'b1;
        reset_n = 1'b1;
        chk("rst_command", command, 32'h0);
        chk("rst_level", {29'b0, level}, 32'd0);
        chk("rst_wr_ready", {31'b0, wr_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_overflow", {31'b0, overflow}, 32'd0);

        // Single write, boundary later
        write(2'd1, 20'h80000);
        step(3);
        pwm_count = '0;
        step(1);
        pwm_count = 20'd5;
        chk("t1_command", command, 32'h40080000);
        chk("t1_valid", {31'b0, cmd_valid}, 32'd1);
        chk("t1_level", {29'b0, level}, 32'd0);
        step(1);
        chk("t1_valid_pulse", {31'b0, cmd_valid}, 32'd0);
        step(2);
        chk("t1_busy_low", {31'b0, busy}, 32'd0);

        // Fill, overflow, drain in order
        write(2'd0, 20'd1);
        write(2'd1, 20'd2);
        write(2'd2, 20'd3);
        write(2'd3, 20'd4);
        chk("t2_wr_ready", {31'b0, wr_ready}, 32'd0);
        chk("t2_level_full", {29'b0, level}, 32'd4);
        write(2'd3, 20'd5);
        chk("t2_overflow", {31'b0, overflow}, COAL ? 32'd0 : 32'd1);
        exp4[0] = 32'h00000001;
        exp4[1] = 32'h40000002;
        exp4[2] = 32'h80000003;
        exp4[3] = COAL ? 32'hC0000005 : 32'hC0000004;
        for (int i = 0; i < 4; i++) boundary_issue("t2_cmd", exp4[i]);

        // Push and pop in the same cycle at level 2
        pwm_count = 20'd5;
        write(2'd0, 20'h11);
        write(2'd1, 20'h16);
        step(2);
        wr_en = 1'b1;
        wr_chan = 2'd2;
        wr_duty = 20'h21;
        pwm_count = '0;
        step(1);
        wr_en = 1'b0;
        pwm_count = 20'd5;
        chk("t3_command", command, 32'h00000011);
        chk("t3_level", {29'b0, level}, 32'd2);
        step(5);
        boundary_issue("t3_cmd2", 32'h40000016);
        boundary_issue("t3_cmd3", 32'h80000021);

        // Count stuck at zero: issues spaced HOLD_CYC+2 apart
        pwm_count = 20'd5;
        write(2'd0, 20'd1);
        write(2'd1, 20'd2);
        pwm_count = '0;
        wait_vld(10, t1);
        wait_vld(10, t2);
        chk("t5_spacing", 32'(t2 - t1), 32'(HOLD_CYC + 2));
        step(6);

        // Reset during HOLD with entries pending
        pwm_count = 20'd5;
        write(2'd0, 20'd7);
        write(2'd1, 20'd8);
        write(2'd2, 20'd9);
        write(2'd3, 20'd10);
        write(2'd3, 20'd11);
        pwm_count = '0;
        step(1);
        pwm_count = 20'd5;
        step(1);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        chk("t4_command", command, 32'h0);
        chk("t4_level", {29'b0, level}, 32'd0);
        chk("t4_overflow", {31'b0, overflow}, 32'd0);
        chk("t4_busy", {31'b0, busy}, 32'd0);
        pwm_count = '0;
        npulse = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (cmd_valid) npulse++;
        end
        chk("t4_no_issue", 32'(npulse), 32'd0);

        // Same-channel rewrite before the boundary
        pwm_count = 20'd5;
        write(2'd2, 20'd10);
        write(2'd2, 20'd99);
        chk("t6_level", {29'b0, level}, COAL ? 32'd1 : 32'd2);
        step(2);
        boundary_issue("t6_cmd1", COAL ? 32'h80000063 : 32'h8000000A);
        if (!COAL) boundary_issue("t6_cmd2", 32'h80000063);

        // Randomised traffic against the model
        for (int i = 0; i < 4000; i++) begin
            reset_n   = ($urandom_range(0, 299) != 0);
            wr_en     = ($urandom_range(0, 99) < 45);
            wr_chan   = 2'($urandom_range(0, 3));
            wr_duty   = 20'($urandom);
            pwm_count = ($urandom_range(0, 3) == 0) ? 20'd0 : 20'($urandom_range(1, 15));
            step(1);
        end
        reset_n = 1'b1;
        wr_en = 1'b0;
        pwm_count = '0;
        step(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
